control_pulse_sequencer: RTL
============================

CONTROL_PULSE_SEQUENCER -- requirements
Module: control_pulse_sequencer

Interface
REQ-001 Parameter MCT_LEN, default 12: number of time pulses per memory cycle; TP counts 1..MCT_LEN.
REQ-002 Parameter BUF_DEPTH, default 2: depth of the control-word buffer, minimum 1.
REQ-003 SIM_CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 SIM_RST  in  1  reset; asynchronous, active-high.
REQ-005 RUN  in  1  advance enable; 0 freezes sequencing.
REQ-006 CP_VALID  in  1  upstream control word valid.
REQ-007 CP_READY  out  1  buffer can accept a word.
REQ-008 CP_WORD  in  9  control word: [2:0] src, [3] src_en, [6:4] dst, [7] dst_en, [8] tt_en.
REQ-009 RT_n, CT_n, WT_n, TT_n  out  1 each  active-low read, clear, write and test timing strobes.
REQ-010 T10_n  out  1  low throughout time pulse 10.
REQ-011 TP  out  4  current time pulse number.
REQ-012 RD_n  out  8  active-low per-register read requests, indexed by src.
REQ-013 WR_n  out  8  active-low per-register write requests, indexed by dst.
REQ-014 UNDERRUN  out  1  one-cycle pulse when a time pulse starts with the buffer empty.

Function
REQ-015 Each time pulse SHALL be 4 clocks, phases P0..P3; phase advances once per clock while RUN=1; P3->P0 increments TP, MCT_LEN wraps to 1.
REQ-016 On the edge entering P0, the buffer head SHALL be popped into the current-word register; if empty, the current word SHALL be NOP (all enables 0) and UNDERRUN SHALL pulse for that P0 cycle.
REQ-017 All outputs except CP_READY SHALL be registered and show the pattern of the phase in the same cycle.
REQ-018 RT_n SHALL be low in P0-P2; CT_n low in P1 only; WT_n low in P2 only; TT_n low in P3 only if tt_en=1.
REQ-019 RD_n[src] SHALL be low in P0-P2 if src_en=1; WR_n[dst] low in P1-P2 if dst_en=1; at most one bit of each bus low at any time.
REQ-020 T10_n SHALL be low in all four phases of TP=10, independent of the current word.
REQ-021 CP_READY SHALL equal (occupancy < BUF_DEPTH), combinational from occupancy; push occurs on CP_VALID and CP_READY.
REQ-022 Simultaneous push and pop SHALL both take effect; occupancy unchanged; no bypass: a word pushed on the pop edge into an empty buffer is not popped there (NOP issued).
REQ-023 When full, CP_READY=0 and CP_VALID SHALL be ignored; buffer order is strictly FIFO.
REQ-024 With RUN=0: phase, TP and current word held; RT_n, CT_n, WT_n, TT_n, RD_n, WR_n all high; UNDERRUN 0; T10_n tracks held TP; pushes still accepted.
REQ-025 When RUN returns to 1 mid-pulse, sequencing SHALL resume at the held phase with the held current word, no refetch.

Reset
REQ-026 On SIM_RST: phase=P3, TP=MCT_LEN, current word=NOP, buffer empty; all active-low outputs high, UNDERRUN=0, CP_READY=1.
REQ-027 Reset mid-pulse SHALL discard the current word and all buffered words immediately; first RUN edge after release enters TP=1 P0 with a fetch.

Structure
REQ-028 Shared package svc_seq_pkg SHALL hold register index constants (A=0, L=1, Q=2, Z=3, B=4, G=5, Y=6, U=7), CP_WORD field positions, the phase enumeration and the NOP word.
REQ-029 Buffer SHALL be a sub-module cp_fifo (parameter BUF_DEPTH, push/pop, occupancy out); phase, TP and strobe decoding stay in the top module.

Verification
REQ-030 Reset, RUN=1, empty buffer -> TP 1,2,...; UNDERRUN pulses each P0; RT_n low P0-P2, CT_n P1, WT_n P2, RD_n/WR_n all 0xFF.
REQ-031 Push word src=A en, dst=Q en, tt_en=1 before TP1 -> at TP1: RD_n=0xFE in P0-P2, WR_n=0xFB in P1-P2, TT_n low P3.
REQ-032 Hold CP_VALID with BUF_DEPTH=2, RUN=0 -> CP_READY drops after 2 pushes; RUN=1 -> words issued in push order, CP_READY rises on first pop.
REQ-033 Run through TP=12 -> TP wraps to 1; T10_n low for exactly 4 clocks at TP=10.
REQ-034 Drop RUN in P1 for 3 clocks -> all strobes high, phase/TP frozen; resume in P1 with same word, WR_n[dst] still low P1-P2.
REQ-035 Assert SIM_RST in P2 with 2 words buffered -> outputs high immediately, CP_READY=1; after release first TP1 issues NOP with UNDERRUN.

Source files
------------

// File: rtl/svc_seq_pkg.sv
// Shared definitions for the control pulse sequencer: register indices,
// control-word layout, phase enumeration and the NOP word.
package svc_seq_pkg;

    localparam int CP_WORD_W  = 9;
    localparam int SRC_LSB    = 0;
    localparam int SRC_MSB    = 2;
    localparam int SRC_EN_BIT = 3;
    localparam int DST_LSB    = 4;
    localparam int DST_MSB    = 6;
    localparam int DST_EN_BIT = 7;
    localparam int TT_EN_BIT  = 8;

    localparam logic [2:0] REG_A = 3'd0;
    localparam logic [2:0] REG_L = 3'd1;
    localparam logic [2:0] REG_Q = 3'd2;
    localparam logic [2:0] REG_Z = 3'd3;
    localparam logic [2:0] REG_B = 3'd4;
    localparam logic [2:0] REG_G = 3'd5;
    localparam logic [2:0] REG_Y = 3'd6;
    localparam logic [2:0] REG_U = 3'd7;

    typedef enum logic [1:0] {
        PH_P0,
        PH_P1,
        PH_P2,
        PH_P3
    } phase_t;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic       tt_en;
        logic       dst_en;
        logic [2:0] dst;
        logic       src_en;
        logic [2:0] src;
    } cp_word_t;

    localparam cp_word_t NOP_WORD = '0;

    function automatic logic [7:0] onehot_low(input logic [2:0] idx, input logic en);
        logic [7:0] bus;
        bus = 8'hFF;
        if (en) begin
            bus[idx] = 1'b0;
        end
        return bus;
    endfunction

endpackage

// File: rtl/control_pulse_sequencer_if.sv
// Valid/ready handshake carrying control words into the sequencer buffer.
interface control_pulse_sequencer_if;
    import svc_seq_pkg::*;

    logic                 CP_VALID;
    logic                 CP_READY;
    logic [CP_WORD_W-1:0] CP_WORD;

    modport master (output CP_VALID, output CP_WORD, input CP_READY);
    modport slave  (input CP_VALID, input CP_WORD, output CP_READY);

endinterface

// File: rtl/control_pulse_sequencer_cp_fifo.sv
// Control-word FIFO: circular buffer with independent push/pop and an
// occupancy count; pop on an empty buffer and push on a full one are ignored.
module cp_fifo
    import svc_seq_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    localparam int CNT_W = $clog2(BUF_DEPTH + 1),
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  cp_word_t         push_word,
    output cp_word_t         head_word,
    output logic [CNT_W-1:0] occupancy
);

    cp_word_t         mem_q [BUF_DEPTH];
    cp_word_t         mem_d [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        do_push  = push && (count_q < CNT_W'(BUF_DEPTH));
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= NOP_WORD;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_word = mem_q[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: rtl/control_pulse_sequencer.sv
// Time-pulse sequencer: four phases per time pulse, fetches one buffered
// control word per pulse and decodes it into registered active-low strobes.
module control_pulse_sequencer
    import svc_seq_pkg::*;
#(
    parameter int MCT_LEN   = 12,
    parameter int BUF_DEPTH = 2
) (
    input  logic                       SIM_CLK,
    input  logic                       SIM_RST,
    input  logic                       RUN,
    control_pulse_sequencer_if.slave   cp,
    output logic                       RT_n,
    output logic                       CT_n,
    output logic                       WT_n,
    output logic                       TT_n,
    output logic                       T10_n,
    output logic [3:0]                 TP,
    output logic [7:0]                 RD_n,
    output logic [7:0]                 WR_n,
    output logic                       UNDERRUN
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    phase_t           phase_q, phase_d;
    logic [3:0]       tp_q, tp_d;
    cp_word_t         cur_q, cur_d;
    logic             rt_n_q, rt_n_d;
    logic             ct_n_q, ct_n_d;
    logic             wt_n_q, wt_n_d;
    logic             tt_n_q, tt_n_d;
    logic             t10_n_q, t10_n_d;
    logic [7:0]       rd_n_q, rd_n_d;
    logic [7:0]       wr_n_q, wr_n_d;
    logic             underrun_q, underrun_d;

    cp_word_t         head_word;
    cp_word_t         in_word;
    logic [CNT_W-1:0] occupancy;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign in_word     = cp_word_t'(cp.CP_WORD);
    assign cp.CP_READY = occupancy < CNT_W'(BUF_DEPTH);
    assign push        = cp.CP_VALID && cp.CP_READY;
    assign fifo_empty  = (occupancy == '0);

    cp_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_cp_fifo (
        .clk       (SIM_CLK),
        .rst       (SIM_RST),
        .push      (push),
        .pop       (pop),
        .push_word (in_word),
        .head_word (head_word),
        .occupancy (occupancy)
    );

    // Strobes are decoded from the next phase/word so the registered outputs
    // line up with the phase they belong to.
    always_comb begin
        phase_d    = phase_q;
        tp_d       = tp_q;
        cur_d      = cur_q;
        pop        = 1'b0;
        underrun_d = 1'b0;
        rt_n_d     = 1'b1;
        ct_n_d     = 1'b1;
        wt_n_d     = 1'b1;
        tt_n_d     = 1'b1;
        rd_n_d     = 8'hFF;
        wr_n_d     = 8'hFF;
        if (RUN) begin
            if (phase_q == PH_P3) begin
                phase_d    = PH_P0;
                tp_d       = (tp_q == 4'(MCT_LEN)) ? 4'd1 : tp_q + 4'd1;
                pop        = !fifo_empty;
                cur_d      = fifo_empty ? NOP_WORD : head_word;
                underrun_d = fifo_empty;
            end else begin
                phase_d = phase_t'(phase_q + 2'd1);
            end
            rt_n_d = (phase_d == PH_P3);
            ct_n_d = (phase_d != PH_P1);
            wt_n_d = (phase_d != PH_P2);
            tt_n_d = !((phase_d == PH_P3) && cur_d.tt_en);
            if (phase_d != PH_P3) begin
                rd_n_d = onehot_low(cur_d.src, cur_d.src_en);
            end
            if ((phase_d == PH_P1) || (phase_d == PH_P2)) begin
                wr_n_d = onehot_low(cur_d.dst, cur_d.dst_en);
            end
        end
        t10_n_d = (tp_d != 4'd10);
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            phase_q    <= PH_P3;
            tp_q       <= 4'(MCT_LEN);
            cur_q      <= NOP_WORD;
            rt_n_q     <= 1'b1;
            ct_n_q     <= 1'b1;
            wt_n_q     <= 1'b1;
            tt_n_q     <= 1'b1;
            t10_n_q    <= 1'b1;
            rd_n_q     <= 8'hFF;
            wr_n_q     <= 8'hFF;
            underrun_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            tp_q       <= tp_d;
            cur_q      <= cur_d;
            rt_n_q     <= rt_n_d;
            ct_n_q     <= ct_n_d;
            wt_n_q     <= wt_n_d;
            tt_n_q     <= tt_n_d;
            t10_n_q    <= t10_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            underrun_q <= underrun_d;
        end
    end

    assign RT_n     = rt_n_q;
    assign CT_n     = ct_n_q;
    assign WT_n     = wt_n_q;
    assign TT_n     = tt_n_q;
    assign T10_n    = t10_n_q;
    assign TP       = tp_q;
    assign RD_n     = rd_n_q;
    assign WR_n     = wr_n_q;
    assign UNDERRUN = underrun_q;

endmodule
